lut_eval_unit: RTL and testbench

LUT_EVAL_UNIT -- requirements
Module: lut_eval_unit

---
 rtl/lut_eval_unit.sv | 122 ++++++++++++
 tb/tb_lut_eval_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_eval_unit.sv
// lut_eval_unit: serially loadable N_IN-input lookup table with 1-cycle evaluation; LUT_EVAL_SWEEP_EN adds a full-table sweep mode
module lut_eval_unit #(
   parameter int                 N_IN = 4,
   parameter logic [2**N_IN-1:0] INIT = 16'hA5C3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_start,
   input  logic            cfg_valid,
   input  logic            cfg_bit,
   input  logic            eval_valid,
   input  logic [N_IN-1:0] eval_in,
   input  logic            sweep_start,
   output logic            eval_ready,
   output logic            y,
   output logic            y_valid,
   output logic [N_IN-1:0] sweep_idx,
   output logic            busy,
   output logic            loaded
);
   localparam logic [N_IN-1:0] LAST = '1;
   typedef enum logic [1:0] {IDLE, LOAD
`ifdef LUT_EVAL_SWEEP_EN
      , SWEEP
`endif
   } state_t;
   state_t             state_q, state_d;
   logic [2**N_IN-1:0] tbl_q, tbl_d;
   logic [N_IN-1:0]    cnt_q, cnt_d;
   logic               y_q, y_d, yv_q, yv_d, loaded_q, loaded_d;
`ifdef LUT_EVAL_SWEEP_EN
   logic [N_IN-1:0]    idx_q, idx_d;
   assign sweep_idx = idx_q;
`else
   logic               unused_sweep_start;
   assign unused_sweep_start = sweep_start;
   assign sweep_idx = '0;
`endif
   assign eval_ready = state_q == IDLE;
   assign busy       = state_q != IDLE;
   assign y          = y_q;
   assign y_valid    = yv_q;
   assign loaded     = loaded_q;
   // next state: start priority cfg > sweep > eval in IDLE; the last load bit and the last sweep step both return to IDLE
   always_comb begin
      state_d  = state_q;
      tbl_d    = tbl_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      yv_d     = 1'b0;
      loaded_d = loaded_q;
`ifdef LUT_EVAL_SWEEP_EN
      idx_d    = idx_q;
`endif
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
`ifdef LUT_EVAL_SWEEP_EN
            else if (sweep_start) begin
               state_d = SWEEP;
               idx_d   = '0;
               y_d     = tbl_q[0];
               yv_d    = 1'b1;
            end
`endif
            else if (eval_valid) begin
               y_d  = tbl_q[eval_in];
               yv_d = 1'b1;
            end
         end
         LOAD: begin
            if (cfg_start) cnt_d = '0;
            else if (cfg_valid) begin
               tbl_d[cnt_q] = cfg_bit;
               cnt_d        = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d  = IDLE;
                  loaded_d = 1'b1;
               end
            end
         end
`ifdef LUT_EVAL_SWEEP_EN
         SWEEP: begin
            if (idx_q == LAST) state_d = IDLE;
            else begin
               idx_d = idx_q + 1'b1;
               y_d   = tbl_q[idx_q + 1'b1];
               yv_d  = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers, all forced to their reset values asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tbl_q    <= INIT;
         cnt_q    <= '0;
         y_q      <= 1'b0;
         yv_q     <= 1'b0;
         loaded_q <= 1'b0;
`ifdef LUT_EVAL_SWEEP_EN
         idx_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         tbl_q    <= tbl_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         yv_q     <= yv_d;
         loaded_q <= loaded_d;
`ifdef LUT_EVAL_SWEEP_EN
         idx_q    <= idx_d;
`endif
      end
   end
endmodule

// File: tb/tb_lut_eval_unit.sv
// tb_lut_eval_unit: randomized self-checking bench for lut_eval_unit against a truth-table model
module tb_lut_eval_unit;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
   logic       eval_valid = 1'b0, sweep_start = 1'b0;
   logic [3:0] eval_in = 4'h0;
   logic       eval_ready, y, y_valid, busy, loaded;
   logic [3:0] sweep_idx;
   int         checks = 0, errors = 0;
   logic [15:0] tbl_m;
   logic        y_m, loaded_m;

   always #5 clk = ~clk;

   lut_eval_unit #(.N_IN(4), .INIT(16'hA5C3)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_bit(cfg_bit), .eval_valid(eval_valid), .eval_in(eval_in),
      .sweep_start(sweep_start), .eval_ready(eval_ready), .y(y), .y_valid(y_valid),
      .sweep_idx(sweep_idx), .busy(busy), .loaded(loaded)
   );

   task automatic load_bits(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            cfg_valid = 1'b0;
            cfg_bit   = 1'($urandom);
            @(negedge clk);
         end
         cfg_valid = 1'b1;
         cfg_bit   = v[i];
         @(negedge clk);
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({busy, loaded, y, y_valid, eval_ready, sweep_idx} !== {5'b00001, 4'h0}) begin
         errors++;
         $display("FAIL reset_state got busy=%b loaded=%b y=%b y_valid=%b ready=%b idx=%h want 0 0 0 0 1 0",
                  busy, loaded, y, y_valid, eval_ready, sweep_idx);
      end
      tbl_m = 16'hA5C3; y_m = 1'b0; loaded_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_eval_init();
      logic [3:0] v [2];
      v[0] = 4'h0; v[1] = 4'h2;
      for (int i = 0; i < 2; i++) begin
         eval_valid = 1'b1; eval_in = v[i];
         @(negedge clk);
         eval_valid = 1'b0;
         y_m = tbl_m[v[i]];
         checks++;
         if (y_valid !== 1'b1 || y !== y_m) begin
            errors++;
            $display("FAIL eval_init in=%h got y=%b y_valid=%b want y=%b y_valid=1", v[i], y, y_valid, y_m);
         end
         @(negedge clk);
         checks++;
         if (y_valid !== 1'b0 || y !== y_m) begin
            errors++;
            $display("FAIL eval_hold got y=%b y_valid=%b want y=%b y_valid=0", y, y_valid, y_m);
         end
      end
   endtask

   task automatic test_back_to_back(input int n);
      logic       pv = 1'b0;
      logic [3:0] pin = 4'h0;
      for (int i = 0; i <= n; i++) begin
         checks++;
         if (pv) y_m = tbl_m[pin];
         if (y_valid !== pv || y !== y_m) begin
            errors++;
            $display("FAIL back_to_back step=%0d in=%h got y=%b y_valid=%b want y=%b y_valid=%b",
                     i, pin, y, y_valid, y_m, pv);
         end
         pv  = (i < n) && ($urandom_range(0, 3) != 0);
         pin = 4'($urandom);
         eval_valid = pv; eval_in = pin;
         @(negedge clk);
      end
      eval_valid = 1'b0;
   endtask

   task automatic test_load(input logic [15:0] v);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      checks++;
      if (busy !== 1'b1 || eval_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_enter got busy=%b ready=%b want 1 0", busy, eval_ready);
      end
      load_bits(v, 16);
      tbl_m = v; loaded_m = 1'b1;
      checks++;
      if (loaded !== 1'b1 || busy !== 1'b0 || eval_ready !== 1'b1 || y_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_done got loaded=%b busy=%b ready=%b y_valid=%b want 1 0 1 0",
                  loaded, busy, eval_ready, y_valid);
      end
      eval_valid = 1'b1; eval_in = 4'hF;
      @(negedge clk);
      eval_in = 4'hE;
      checks++;
      if (y_valid !== 1'b1 || y !== tbl_m[15]) begin
         errors++;
         $display("FAIL load_eval_F got y=%b y_valid=%b want y=%b y_valid=1", y, y_valid, tbl_m[15]);
      end
      @(negedge clk);
      eval_valid = 1'b0;
      y_m = tbl_m[14];
      checks++;
      if (y_valid !== 1'b1 || y !== y_m) begin
         errors++;
         $display("FAIL load_eval_E got y=%b y_valid=%b want y=%b y_valid=1", y, y_valid, y_m);
      end
      @(negedge clk);
   endtask

`ifdef LUT_EVAL_SWEEP_EN
   task automatic test_sweep();
      sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (busy !== 1'b1 || y_valid !== 1'b1 || eval_ready !== 1'b0 ||
             sweep_idx !== 4'(k) || y !== tbl_m[k]) begin
            errors++;
            $display("FAIL sweep k=%0d got busy=%b y_valid=%b ready=%b idx=%h y=%b want 1 1 0 %h %b",
                     k, busy, y_valid, eval_ready, sweep_idx, y, 4'(k), tbl_m[k]);
         end
         cfg_start   = (k == 3);
         eval_valid  = (k == 3);
         sweep_start = (k == 3);
         @(negedge clk);
      end
      y_m = tbl_m[15];
      checks++;
      if (busy !== 1'b0 || y_valid !== 1'b0 || sweep_idx !== 4'hF || y !== y_m || loaded !== loaded_m) begin
         errors++;
         $display("FAIL sweep_end got busy=%b y_valid=%b idx=%h y=%b loaded=%b want 0 0 f %b %b",
                  busy, y_valid, sweep_idx, y, loaded, y_m, loaded_m);
      end
   endtask
`else
   task automatic test_sweep_disabled();
      sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (busy !== 1'b0 || y_valid !== 1'b0 || sweep_idx !== 4'h0 || y !== y_m) begin
            errors++;
            $display("FAIL sweep_disabled got busy=%b y_valid=%b idx=%h y=%b want 0 0 0 %b",
                     busy, y_valid, sweep_idx, y, y_m);
         end
         @(negedge clk);
      end
   endtask
`endif

   task automatic test_priority();
      logic [15:0] a, b;
      a = 16'($urandom); b = 16'($urandom);
      cfg_start = 1'b1; sweep_start = 1'b1; eval_valid = 1'b1; eval_in = 4'($urandom);
      @(negedge clk);
      cfg_start = 1'b0; sweep_start = 1'b0; eval_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || y_valid !== 1'b0 || eval_ready !== 1'b0 || sweep_idx !== 4'h0) begin
         errors++;
         $display("FAIL priority got busy=%b y_valid=%b ready=%b idx=%h want 1 0 0 0",
                  busy, y_valid, eval_ready, sweep_idx);
      end
      load_bits(a, 7);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      load_bits(b, 16);
      tbl_m = b;
      checks++;
      if (loaded !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL restart_load got loaded=%b busy=%b want 1 0", loaded, busy);
      end
   endtask

   task automatic test_async_reset();
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      load_bits(16'($urandom), 7);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midload_busy got %b want 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, loaded, y, y_valid, eval_ready, sweep_idx} !== {5'b00001, 4'h0}) begin
         errors++;
         $display("FAIL async_reset got busy=%b loaded=%b y=%b y_valid=%b ready=%b idx=%h want 0 0 0 0 1 0",
                  busy, loaded, y, y_valid, eval_ready, sweep_idx);
      end
      tbl_m = 16'hA5C3; y_m = 1'b0; loaded_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         if (i > 0) begin
            y_m = tbl_m[i-1];
            checks++;
            if (y_valid !== 1'b1 || y !== y_m) begin
               errors++;
               $display("FAIL reset_table in=%h got y=%b y_valid=%b want y=%b", 4'(i-1), y, y_valid, y_m);
            end
         end
         eval_valid = (i < 16); eval_in = 4'(i);
         @(negedge clk);
      end
      eval_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_eval_init();
      test_back_to_back(30);
      test_load(16'h8000);
`ifdef LUT_EVAL_SWEEP_EN
      test_sweep();
`else
      test_sweep_disabled();
`endif
      test_priority();
      test_back_to_back(40);
`ifdef LUT_EVAL_SWEEP_EN
      test_sweep();
`endif
      test_async_reset();
      test_back_to_back(20);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
